// File: rtl/frac_baud_generator.sv
// ---------------------------------------------------------------------------
// frac_baud_generator
//
// Fractional baud-rate generator for a UART. A period counter produces
// rxTick at OVERSAMPLE x baud; the period alternates between divInt and
// divInt+1 clocks under control of a fractional accumulator so the average
// period is divInt + divFrac/2^FRAC_WIDTH clocks with no long-term drift.
// Two phase counters divide rxTick down to the receive mid-bit sample
// strobe (rxSample) and the transmit bit strobe (txTick).
//
// Ports
//   clk       : single clock, rising edge
//   reset     : synchronous, active-high reset
//   enable    : runs the generator; low holds all counters at zero
//   load      : one-cycle strobe capturing divInt/divFrac into shadow regs
//   divInt    : integer clocks per rxTick (values below 2 are clamped to 2)
//   divFrac   : fractional clocks per rxTick, in 1/2^FRAC_WIDTH units
//   rxSync    : zeroes the receive phase (start-bit alignment)
//   txSync    : zeroes the transmit phase
//   rxTick    : one-cycle pulse at OVERSAMPLE x baud
//   rxSample  : one-cycle pulse at the mid-bit sample point
//   txTick    : one-cycle pulse at the baud rate
//   cfgErr    : sticky flag, an illegal divisor was loaded
// ---------------------------------------------------------------------------
module frac_baud_generator #(
    parameter int DIV_WIDTH        = 16,
    parameter int FRAC_WIDTH       = 4,
    parameter int OVERSAMPLE       = 16,
    parameter int DEFAULT_DIV_INT  = 27,
    parameter int DEFAULT_DIV_FRAC = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  load,
    input  logic [DIV_WIDTH-1:0]  divInt,
    input  logic [FRAC_WIDTH-1:0] divFrac,
    input  logic                  rxSync,
    input  logic                  txSync,
    output logic                  rxTick,
    output logic                  rxSample,
    output logic                  txTick,
    output logic                  cfgErr
);

    localparam int PHASE_WIDTH = $clog2(OVERSAMPLE);
    localparam int RESET_INT   = (DEFAULT_DIV_INT < 2) ? 2 : DEFAULT_DIV_INT;

    localparam logic [DIV_WIDTH-1:0]   MIN_DIV        = DIV_WIDTH'(2);
    localparam logic [DIV_WIDTH-1:0]   RESET_DIV_INT  = DIV_WIDTH'(RESET_INT);
    localparam logic [FRAC_WIDTH-1:0]  RESET_DIV_FRAC = FRAC_WIDTH'(DEFAULT_DIV_FRAC);
    localparam logic [PHASE_WIDTH-1:0] PHASE_LAST     = PHASE_WIDTH'(OVERSAMPLE - 1);
    localparam logic [PHASE_WIDTH-1:0] PHASE_PRE_MID  = PHASE_WIDTH'(OVERSAMPLE / 2 - 1);

    logic [DIV_WIDTH-1:0]   shadowInt_q, shadowInt_d;
    logic [FRAC_WIDTH-1:0]  shadowFrac_q, shadowFrac_d;
    logic [DIV_WIDTH-1:0]   activeInt_q, activeInt_d;
    logic [FRAC_WIDTH-1:0]  activeFrac_q, activeFrac_d;
    logic [DIV_WIDTH-1:0]   cnt_q, cnt_d;
    logic [FRAC_WIDTH-1:0]  fracAcc_q, fracAcc_d;
    logic                   carry_q, carry_d;
    logic                   run_q, run_d;
    logic [PHASE_WIDTH-1:0] rxPhase_q, rxPhase_d;
    logic [PHASE_WIDTH-1:0] txPhase_q, txPhase_d;
    logic                   rxTick_q, rxTick_d;
    logic                   rxSample_q, rxSample_d;
    logic                   txTick_q, txTick_d;
    logic                   cfgErr_q, cfgErr_d;

    logic [DIV_WIDTH:0]     periodLast;
    logic [FRAC_WIDTH:0]    fracSum;
    logic                   terminal;

    // Shadow divisor capture. A divisor below 2 cannot produce a one-cycle
    // pulse followed by a low cycle, so it is clamped and flagged instead.
    always_comb begin
        shadowInt_d  = shadowInt_q;
        shadowFrac_d = shadowFrac_q;
        cfgErr_d     = cfgErr_q;
        if (load) begin
            shadowFrac_d = divFrac;
            if (divInt < MIN_DIV) begin
                shadowInt_d = MIN_DIV;
                cfgErr_d    = 1'b1;
            end else begin
                shadowInt_d = divInt;
            end
        end
    end

    // The last count of the current period is activeInt-1, stretched by one
    // when the previous tick overflowed the fractional accumulator. The extra
    // bit keeps activeInt = 2^DIV_WIDTH-1 plus carry from wrapping.
    assign periodLast = {1'b0, activeInt_q} + (DIV_WIDTH + 1)'(carry_q) - (DIV_WIDTH + 1)'(1);
    assign fracSum    = {1'b0, fracAcc_q} + {1'b0, activeFrac_q};
    assign terminal   = enable && run_q && ({1'b0, cnt_q} == periodLast);

    // Period counter, fractional accumulator and phase dividers. run_q marks
    // that enable was already high on the previous edge; the edge that first
    // sees enable only arms the counter, so the first tick lands activeInt
    // edges later. The active divisor follows the shadow (including a load
    // on this same edge) only at period boundaries or while idle, so a load
    // never reshapes a period already in progress. Sync inputs override the
    // phase update of a coincident tick and suppress its derived strobe.
    always_comb begin
        cnt_d        = cnt_q;
        fracAcc_d    = fracAcc_q;
        carry_d      = carry_q;
        run_d        = run_q;
        activeInt_d  = activeInt_q;
        activeFrac_d = activeFrac_q;
        rxPhase_d    = rxPhase_q;
        txPhase_d    = txPhase_q;
        rxTick_d     = 1'b0;
        rxSample_d   = 1'b0;
        txTick_d     = 1'b0;

        if (!enable) begin
            cnt_d        = '0;
            fracAcc_d    = '0;
            carry_d      = 1'b0;
            run_d        = 1'b0;
            rxPhase_d    = '0;
            txPhase_d    = '0;
            activeInt_d  = shadowInt_d;
            activeFrac_d = shadowFrac_d;
        end else begin
            run_d = 1'b1;
            if (!run_q) begin
                cnt_d = '0;
            end else if (terminal) begin
                cnt_d        = '0;
                rxTick_d     = 1'b1;
                fracAcc_d    = fracSum[FRAC_WIDTH-1:0];
                carry_d      = fracSum[FRAC_WIDTH];
                activeInt_d  = shadowInt_d;
                activeFrac_d = shadowFrac_d;
                rxPhase_d    = rxPhase_q + PHASE_WIDTH'(1);
                txPhase_d    = txPhase_q + PHASE_WIDTH'(1);
                rxSample_d   = (rxPhase_q == PHASE_PRE_MID);
                txTick_d     = (txPhase_q == PHASE_LAST);
            end else begin
                cnt_d = cnt_q + DIV_WIDTH'(1);
            end

            if (rxSync) begin
                rxPhase_d  = '0;
                rxSample_d = 1'b0;
            end
            if (txSync) begin
                txPhase_d = '0;
                txTick_d  = 1'b0;
            end
        end
    end

    // State register. Reset restores the default divisor in both the shadow
    // and the active copy and silences every output on the following cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadowInt_q  <= RESET_DIV_INT;
            shadowFrac_q <= RESET_DIV_FRAC;
            activeInt_q  <= RESET_DIV_INT;
            activeFrac_q <= RESET_DIV_FRAC;
            cnt_q        <= '0;
            fracAcc_q    <= '0;
            carry_q      <= 1'b0;
            run_q        <= 1'b0;
            rxPhase_q    <= '0;
            txPhase_q    <= '0;
            rxTick_q     <= 1'b0;
            rxSample_q   <= 1'b0;
            txTick_q     <= 1'b0;
            cfgErr_q     <= 1'b0;
        end else begin
            shadowInt_q  <= shadowInt_d;
            shadowFrac_q <= shadowFrac_d;
            activeInt_q  <= activeInt_d;
            activeFrac_q <= activeFrac_d;
            cnt_q        <= cnt_d;
            fracAcc_q    <= fracAcc_d;
            carry_q      <= carry_d;
            run_q        <= run_d;
            rxPhase_q    <= rxPhase_d;
            txPhase_q    <= txPhase_d;
            rxTick_q     <= rxTick_d;
            rxSample_q   <= rxSample_d;
            txTick_q     <= txTick_d;
            cfgErr_q     <= cfgErr_d;
        end
    end

    assign rxTick   = rxTick_q;
    assign rxSample = rxSample_q;
    assign txTick   = txTick_q;
    assign cfgErr   = cfgErr_q;

endmodule

// File: doc/frac_baud_generator.md
FRAC_BAUD_GENERATOR -- requirements
Module: frac_baud_generator

Interface
REQ-001 The block SHALL have parameter DIV_WIDTH, default 16: width of the integer divisor.
REQ-002 The block SHALL have parameter FRAC_WIDTH, default 4: width of the fractional divisor, in units of 1/2^FRAC_WIDTH.
REQ-003 The block SHALL have parameter OVERSAMPLE, default 16: rxTick pulses per bit; power of two, at least 4.
REQ-004 The block SHALL have parameter DEFAULT_DIV_INT, default 27: integer divisor after reset.
REQ-005 The block SHALL have parameter DEFAULT_DIV_FRAC, default 0: fractional divisor after reset.
REQ-006 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-007 Port reset, input, 1 bit, SHALL be a synchronous, active-high reset.
REQ-008 Port enable, input, 1 bit, SHALL run the generator when high.
REQ-009 Port load, input, 1 bit, SHALL be a one-cycle strobe that captures divInt and divFrac into the shadow registers.
REQ-010 Port divInt, input, DIV_WIDTH bits, SHALL carry the integer clocks per rxTick.
REQ-011 Port divFrac, input, FRAC_WIDTH bits, SHALL carry the fractional clocks per rxTick.
REQ-012 Port rxSync, input, 1 bit, SHALL realign the receive phase (driven at start-bit detection).
REQ-013 Port txSync, input, 1 bit, SHALL realign the transmit phase.
REQ-014 Port rxTick, output, 1 bit, SHALL be a one-cycle pulse at OVERSAMPLE x baud.
REQ-015 Port rxSample, output, 1 bit, SHALL be a one-cycle pulse at the mid-bit sample point.
REQ-016 Port txTick, output, 1 bit, SHALL be a one-cycle pulse at the baud rate.
REQ-017 Port cfgErr, output, 1 bit, SHALL be a sticky flag meaning an illegal divisor was loaded.

Function
REQ-018 All outputs SHALL be registered; rxTick, rxSample and txTick SHALL each be high for exactly one clk cycle per event.
REQ-019 Period counter: the block SHALL count clk cycles 0..P-1, where P = activeInt + carry; rxTick SHALL assert on the edge that ends count P-1.
REQ-020 On each rxTick edge, the block SHALL set fracAcc <= (fracAcc + activeFrac) mod 2^FRAC_WIDTH; carry SHALL be 1 for the next period only if the sum is >= 2^FRAC_WIDTH.
REQ-021 The average rxTick period SHALL be activeInt + activeFrac/2^FRAC_WIDTH cycles, with zero long-term drift.
REQ-022 When the enable rising edge is sampled at edge E, the first rxTick SHALL go high at edge E+activeInt, with carry = 0.
REQ-023 When enable = 0: the period counter, fracAcc, carry, rxPhase and txPhase SHALL be held at 0; no pulses SHALL be issued; active and shadow divisors SHALL be retained.
REQ-024 load SHALL write the shadow registers on the next edge; a divInt value below 2 SHALL be stored as 2 and SHALL set cfgErr.
REQ-025 The active divisor SHALL be copied from shadow on every rxTick edge and whenever enable = 0, so period lengths never glitch mid-period.
REQ-026 When load coincides with the terminal count, the new value SHALL apply to the immediately following period.
REQ-027 load SHALL NOT clear fracAcc.
REQ-028 txPhase SHALL count rxTicks modulo OVERSAMPLE; txTick SHALL assert together with the rxTick that wraps txPhase from OVERSAMPLE-1 to 0.
REQ-029 rxPhase SHALL count rxTicks modulo OVERSAMPLE; rxSample SHALL assert together with the rxTick that moves rxPhase to OVERSAMPLE/2.
REQ-030 rxSync SHALL set rxPhase to 0 on the next edge; txSync SHALL set txPhase to 0; neither SHALL affect the period counter or fracAcc.
REQ-031 When a sync input coincides with an rxTick, the sync SHALL win: the phase SHALL be 0 and the associated rxSample/txTick SHALL be suppressed (rxTick itself still SHALL assert).
REQ-032 With rxSync held high, rxSample SHALL never assert; with txSync held high, txTick SHALL never assert.
REQ-033 cfgErr SHALL clear only on reset.

Reset
REQ-034 When reset is high at an edge, every output SHALL be 0 after that edge, regardless of enable, load or sync.
REQ-035 On reset, all counters, fracAcc and carry SHALL clear, and active and shadow divisors SHALL be set to DEFAULT_DIV_INT/DEFAULT_DIV_FRAC (DEFAULT_DIV_INT below 2 SHALL be treated as 2).
REQ-036 Reset asserted mid-period SHALL stop pulses from the next edge; after release with enable high, timing SHALL follow REQ-022.

Verification
REQ-037 Reset; load divInt=4, divFrac=0; enable rises at edge 0 -> rxTick at edges 4, 8, 12, ...; txTick at edge 64, then every 64 edges; rxSample first at edge 32.
REQ-038 divInt=4, divFrac=8 (FRAC_WIDTH=4) -> rxTick intervals 4, 4, 5, 4, 5, ...; 16th rxTick at edge 71.
REQ-039 Load divInt=6 two cycles before a tick of a divInt=4 stream -> that period remains 4 cycles; following periods are 6 cycles; no short or runt period.
REQ-040 Pulse rxSync one cycle at an arbitrary point -> next rxSample exactly 8 rxTicks later (OVERSAMPLE=16); rxSync on a tick edge -> that tick still asserts, rxSample count restarts from it.
REQ-041 Load divInt=1 -> cfgErr=1 and period of 2 cycles; cfgErr remains 1 until reset.
REQ-042 Reset mid-stream -> all outputs 0 next cycle; divisor reverts to DEFAULT_DIV_INT=27; first rxTick 27 edges after enable is sampled.
